// File: rtl/sync_bd4_tx_pkg.sv
// Shared definitions for the clocked-to-four-phase bundled-data bridge:
// default word width and the handshake FSM state encoding.
package sync_bd4_tx_pkg;

  localparam int DATA_MSB = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_REQ   = 2'd2,
    ST_REL   = 2'd3
  } state_t;

endpackage

// File: rtl/sync_bd4_tx_if.sv
// Producer-side valid/ready bus plus four-phase req/ack channel of the bridge.
// The slave modport is the bridge's view; master is the environment's view.
interface sync_bd4_tx_if
  import sync_bd4_tx_pkg::*;
#(
  parameter int DATA_W = DATA_MSB + 1,
  parameter int DEPTH  = 4
);

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic                    out_req;
  logic                    out_ack;
  logic [DATA_W-1:0]       out_data;
  logic [$clog2(DEPTH):0]  level;

  modport master (
    output in_valid, in_data, out_ack,
    input  in_ready, out_req, out_data, level
  );

  modport slave (
    input  in_valid, in_data, out_ack,
    output in_ready, out_req, out_data, level
  );

endinterface

// File: rtl/sync_bd4_tx_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit; kept as its own
// module so the clock-domain-crossing flops are easy to locate and constrain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/sync_bd4_tx.sv
// Bridge from a synchronous valid/ready producer to a four-phase bundled-data
// channel: small FIFO, acknowledge synchronizer and a req/ack sequencer.
module sync_bd4_tx
  import sync_bd4_tx_pkg::*;
#(
  parameter int DATA_W      = DATA_MSB + 1,
  parameter int DEPTH       = 4,
  parameter int SETUP_CYC   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  sync_bd4_tx_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [LVL_W-1:0]  level;
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              out_req;
  logic [DATA_W-1:0] out_data;
  logic              ack_s;
  logic              push;
  logic              pop;

  sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.out_ack),
    .q       (ack_s)
  );

  // Full is judged on the registered level, so a same-cycle pop never frees a slot early.
  assign bus.in_ready = (level != LVL_W'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state == ST_REQ) && ack_s;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Handshake sequencer; ack_s is only acted upon in REQ and REL, so early acks are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      out_req  <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (level != '0) begin
            out_data <= mem[rptr];
            cnt      <= CNT_W'(SETUP_CYC - 1);
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            out_req <= 1'b1;
            state   <= ST_REQ;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_REQ: begin
          if (ack_s) begin
            out_req <= 1'b0;
            state   <= ST_REL;
          end
        end
        ST_REL: begin
          if (!ack_s) begin
            if (level != '0) begin
              out_data <= mem[rptr];
              cnt      <= CNT_W'(SETUP_CYC - 1);
              state    <= ST_SETUP;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_req  = out_req;
  assign bus.out_data = out_data;
  assign bus.level    = level;

endmodule
